// File: rtl/mdu_pkg.sv
// Shared types and operation codes for the multiply/divide unit.
// HI/LO payloads travel as a packed pair so products and div results load in one assignment.
package mdu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        MDUOP_NONE  = 4'd0,
        MDUOP_MULT  = 4'd1,
        MDUOP_MULTU = 4'd2,
        MDUOP_DIV   = 4'd3,
        MDUOP_DIVU  = 4'd4,
        MDUOP_MTHI  = 4'd5,
        MDUOP_MTLO  = 4'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } mdu_hilo_t;

endpackage

// File: rtl/mdu_if.sv
// Issue/read bus between the EX stage and the multiply/divide unit.
interface mdu_if;
    import mdu_pkg::*;

    logic              start;
    logic [OP_W-1:0]   operation;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic              read_select;
    logic              busy;
    logic [DATA_W-1:0] result;

    modport master (
        output start, operation, operand1, operand2, read_select,
        input  busy, result
    );

    modport slave (
        input  start, operation, operand1, operand2, read_select,
        output busy, result
    );

endinterface

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: fixed-latency MULT*/DIV*, single-cycle MTHI/MTLO.
// Results are computed at issue, parked in pending regs, and committed when the countdown expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e        r_state;
    mdu_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    mdu_hilo_t         r_arch;
    mdu_hilo_t         r_pend;
    logic              r_pend_wr;

    logic              w_is_mult;
    logic              w_is_div;
    logic              w_commit;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [DATA_W-1:0] w_sdivisor;
    logic [DATA_W-1:0] w_udivisor;
    logic signed [DATA_W-1:0] w_sq;
    logic signed [DATA_W-1:0] w_sr;
    logic [DATA_W-1:0] w_uq;
    logic [DATA_W-1:0] w_ur;

    assign w_is_mult = (bus.operation == MDUOP_MULT) || (bus.operation == MDUOP_MULTU);
    assign w_is_div  = (bus.operation == MDUOP_DIV)  || (bus.operation == MDUOP_DIVU);
    assign w_commit  = (r_state == ST_RUN) && (r_count == CNT_W'(1));

    assign w_prod_s = 64'($signed(bus.operand1)) * 64'($signed(bus.operand2));
    assign w_prod_u = 64'(bus.operand1) * 64'(bus.operand2);

    // Divide-by-zero and MIN/-1 are steered to a divisor of 1: MIN/1 already gives the
    // architected overflow answer, and a zero-divide result is never committed.
    assign w_div_zero = (bus.operand2 == '0);
    assign w_div_ovf  = (bus.operand1 == 32'h8000_0000) && (bus.operand2 == 32'hFFFF_FFFF);
    assign w_sdivisor = (w_div_zero || w_div_ovf) ? 32'd1 : bus.operand2;
    assign w_udivisor = w_div_zero ? 32'd1 : bus.operand2;
    assign w_sq = $signed(bus.operand1) / $signed(w_sdivisor);
    assign w_sr = $signed(bus.operand1) % $signed(w_sdivisor);
    assign w_uq = bus.operand1 / w_udivisor;
    assign w_ur = bus.operand1 % w_udivisor;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start && (w_is_mult || w_is_div)) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_commit) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: busy decodes the state register, result reads architectural HI/LO only
    always_comb begin
        bus.busy   = 1'b0;
        bus.result = r_arch.lo;
        if (r_state == ST_RUN) bus.busy = 1'b1;
        if (bus.read_select)   bus.result = r_arch.hi;
    end

    // Datapath: issue captures pending results, countdown commits them
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count   <= '0;
            r_arch    <= '0;
            r_pend    <= '0;
            r_pend_wr <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (bus.start) begin
                case (bus.operation)
                    MDUOP_MULT: begin
                        r_pend    <= w_prod_s;
                        r_pend_wr <= 1'b1;
                        r_count   <= CNT_W'(MULT_CYCLES);
                    end
                    MDUOP_MULTU: begin
                        r_pend    <= w_prod_u;
                        r_pend_wr <= 1'b1;
                        r_count   <= CNT_W'(MULT_CYCLES);
                    end
                    MDUOP_DIV: begin
                        r_pend    <= {w_sr, w_sq};
                        r_pend_wr <= !w_div_zero;
                        r_count   <= CNT_W'(DIV_CYCLES);
                    end
                    MDUOP_DIVU: begin
                        r_pend    <= {w_ur, w_uq};
                        r_pend_wr <= !w_div_zero;
                        r_count   <= CNT_W'(DIV_CYCLES);
                    end
                    MDUOP_MTHI: r_arch.hi <= bus.operand1;
                    MDUOP_MTLO: r_arch.lo <= bus.operand1;
                    default: ;
                endcase
            end
        end else begin
            r_count <= r_count - CNT_W'(1);
            if (w_commit && r_pend_wr) begin
                r_arch <= r_pend;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO from an arithmetic model,
// a monitor pops on completion and also checks that result holds old HI/LO while busy.
module tb_mdu;
    import mdu_pkg::*;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mdu_if bus();

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_long;
        int unsigned cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec      = 0;
    int          n_err      = 0;
    int          proto_hits = 0;
    logic [31:0] m_hi       = '0;
    logic [31:0] m_lo       = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Issuing while busy violates the stall protocol; count each occurrence
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            assert (!(bus.start === 1'b1 && bus.busy === 1'b1)) else proto_hits = proto_hits + 1;
        end
    end

    // Monitor: owns read_select, pops expectations when the DUT completes
    initial begin : monitor
        logic [31:0] c_hi;
        logic [31:0] c_lo;
        logic [31:0] rh;
        logic [31:0] rl;
        logic        prev_busy;
        int          busy_cnt;
        int          age;
        exp_t        e;
        c_hi = '0; c_lo = '0; prev_busy = 1'b0; busy_cnt = 0; age = 0;
        bus.read_select = 1'b0;
        forever begin
            @(negedge clk);
            bus.read_select = 1'b1;
            #1 rh = bus.result;
            bus.read_select = 1'b0;
            #1 rl = bus.result;
            age = (sb_q.size() > 0) ? age + 1 : 0;
            if (age > int'(DIV_N) + 20) begin
                n_vec++; n_err++;
                $display("FAIL timeout: busy=%b, no completion after %0d cycles, expected one", bus.busy, age);
                void'(sb_q.pop_front());
                age = 0;
            end
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                check("hi_held_while_busy", rh, c_hi);
                check("lo_held_while_busy", rl, c_lo);
            end else begin
                if (sb_q.size() > 0 && (!sb_q[0].is_long || prev_busy)) begin
                    e = sb_q.pop_front();
                    age = 0;
                    if (e.is_long) check("busy_cycles", 32'(busy_cnt), 32'(e.cycles));
                    check("hi", rh, e.hi);
                    check("lo", rl, e.lo);
                    c_hi = e.hi;
                    c_lo = e.lo;
                end
                busy_cnt = 0;
            end
            prev_busy = (bus.busy === 1'b1);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", bus.busy, n);
        end
    endtask

    // Expected outcome from plain 64-bit arithmetic on the architectural rules
    task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        longint          sp;
        longint unsigned up;
        longint          sq;
        longint          sr;
        exp_t            e;
        wait_idle();
        bus.start = 1'b1; bus.operation = op; bus.operand1 = a; bus.operand2 = b;
        @(posedge clk);
        e.is_long = 1'b0;
        e.cycles  = 0;
        case (op)
            4'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32]; m_lo = sp[31:0];
                e.is_long = 1'b1; e.cycles = MULT_N;
            end
            4'd2: begin
                up = longint'(a) * longint'(b);
                m_hi = up[63:32]; m_lo = up[31:0];
                e.is_long = 1'b1; e.cycles = MULT_N;
            end
            4'd3: begin
                if (b != 0) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    m_hi = sr[31:0]; m_lo = sq[31:0];
                end
                e.is_long = 1'b1; e.cycles = DIV_N;
            end
            4'd4: begin
                if (b != 0) begin
                    m_lo = a / b; m_hi = a % b;
                end
                e.is_long = 1'b1; e.cycles = DIV_N;
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
        e.hi = m_hi; e.lo = m_lo;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0; bus.operation = 4'd0;
    endtask

    task automatic do_reset();
        exp_t e;
        reset = 1'b0;
        @(posedge clk);
        sb_q.delete();
        m_hi = '0; m_lo = '0;
        e.is_long = 1'b0; e.cycles = 0; e.hi = '0; e.lo = '0;
        sb_q.push_back(e);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic expect_now();
        exp_t e;
        @(posedge clk);
        e.is_long = 1'b0; e.cycles = 0; e.hi = m_hi; e.lo = m_lo;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] op;
        bus.start = 1'b0; bus.operation = 4'd0; bus.operand1 = '0; bus.operand2 = '0;
        @(negedge clk);
        do_reset();

        // Abort an in-flight MULT with reset; nothing may commit afterwards
        issue(4'd1, 32'd3, 32'd4);
        @(negedge clk);
        do_reset();
        repeat (7) @(negedge clk);
        expect_now();

        issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        issue(4'd4, 32'd7, 32'd2);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd5, 32'h11, 32'h0);
        issue(4'd6, 32'h22, 32'h0);
        issue(4'd4, 32'd5, 32'd0);
        issue(4'd5, 32'hDEAD_BEEF, 32'h0);
        issue(4'd6, 32'h1234_5678, 32'h0);
        issue(4'd0, 32'hAAAA_AAAA, 32'h5555_5555);
        issue(4'd9, 32'hAAAA_AAAA, 32'h5555_5555);

        // MULT issued mid-DIV must be dropped
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.operation = 4'd1; bus.operand1 = 32'd5; bus.operand2 = 32'd6;
        @(negedge clk);
        bus.start = 1'b0; bus.operation = 4'd0;

        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
            issue(op, pick(), pick());
        end

        wait_idle();
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("protocol_assert_hits", 32'(proto_hits), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
